// File: rtl/mem_port_arbiter.sv
// Shares the memory data port between the CPU data path and a burst DMA
// requester. Define MEM_PORT_ARB_STARVE_EN to bound the DMA waiting time.
module mem_port_arbiter #(
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_stall
);

  if (BURST_MAX < 1 || BURST_MAX > 16) begin : gBadBurst
    $error("BURST_MAX must be 1..16");
  end
  if (STARVE_LIMIT < 1) begin : gBadLimit
    $error("STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    DMA_BURST,
    DMA_DRAIN
  } state_t;

  localparam logic [4:0] BMAX = 5'(BURST_MAX);

  state_t      state;
  logic [31:0] baseAddr;
  logic [4:0]  lenQ;
  logic [4:0]  beatCnt;
  logic        isWrite;
  logic        pendRet;
  logic        doneQ;

  logic        cpuPend;
  logic        starveHit;
  logic        dmaWin;
  logic        accept;
  logic        capture;
  logic        lastBeat;
  logic [4:0]  lenEff;

  assign cpuPend  = cpu_re | (|cpu_we);
  assign dmaWin   = !rst && state == IDLE && dma_req
                    && (!cpuPend || starveHit);
  assign accept   = !rst && state == DMA_BURST && !mem_stall;
  assign capture  = !rst && pendRet && !mem_stall;
  assign lastBeat = beatCnt == lenQ - 5'd1;

  always_comb begin
    lenEff = {1'b0, dma_len};
    if (dma_len == 4'd0 || {1'b0, dma_len} > BMAX)
      lenEff = BMAX;
  end

`ifdef MEM_PORT_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] starveCnt;

  assign starveHit = starveCnt == SLIM;

  always_ff @(posedge clk) begin
    if (rst)
      starveCnt <= '0;
    else if (dmaWin)
      starveCnt <= '0;
    else if (state == IDLE && dma_req && cpuPend && !starveHit)
      starveCnt <= starveCnt + 1'b1;
  end
`else
  assign starveHit = 1'b0;
`endif

  // At most one read beat is ever awaiting its return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baseAddr <= '0;
      lenQ     <= '0;
      beatCnt  <= '0;
      isWrite  <= 1'b0;
      pendRet  <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (accept && !isWrite)
        pendRet <= 1'b1;
      else if (capture)
        pendRet <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dmaWin) begin
            baseAddr <= dma_addr & 32'hFFFF_FFFC;
            lenQ     <= lenEff;
            isWrite  <= dma_we;
            beatCnt  <= '0;
            state    <= DMA_BURST;
          end
        end
        DMA_BURST: begin
          if (accept) begin
            beatCnt <= beatCnt + 5'd1;
            if (lastBeat) begin
              if (isWrite) begin
                state <= IDLE;
                doneQ <= 1'b1;
              end else begin
                state <= DMA_DRAIN;
              end
            end
          end
        end
        DMA_DRAIN: begin
          if (capture)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_re   = cpu_re;
    mem_we   = cpu_we;
    mem_din  = cpu_din;
    if (state == DMA_BURST) begin
      mem_addr = baseAddr + {25'd0, beatCnt, 2'b00};
      mem_re   = !isWrite;
      mem_we   = isWrite ? 4'hF : 4'h0;
      mem_din  = dma_wdata;
    end else if (state == DMA_DRAIN) begin
      mem_re = 1'b0;
      mem_we = 4'h0;
    end
    if (dmaWin || rst) begin
      mem_re = 1'b0;
      mem_we = 4'h0;
    end
  end

  assign cpu_dout   = mem_dout;
  assign dma_rdata  = mem_dout;
  assign dma_gnt    = accept;
  assign dma_rvalid = capture;
  assign dma_done   = (doneQ && !rst)
                      || (capture && state == DMA_DRAIN);
  assign cpu_stall  = rst || mem_stall
                      || (cpuPend && state != IDLE)
                      || (cpuPend && dmaWin);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: CPU passthrough, DMA bursts,
// read returns under stall, starvation guard and mid-burst reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        dmaReq;
  logic        dmaReqPort;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_stall;

  logic [31:0] rdAddr = 32'h0;
  logic [31:0] expQ[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Requester releases its request as soon as it sees completion.
  assign dmaReqPort = dmaReq & ~dma_done;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  always @(posedge clk)
    if (mem_re && !mem_stall) rdAddr <= mem_addr;

  assign mem_dout = memWord(rdAddr);

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dma_req(dmaReqPort), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_stall(mem_stall)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_re = 1'b1;
    cpu_addr = 32'h40;
    step();
    step();
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_cpu_stall got %b exp 1", cpu_stall);
    end
    checks++;
    if (mem_re !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_re got %b exp 0", mem_re);
    end
    checks++;
    if (mem_we !== 4'h0) begin
      errors++;
      $display("FAIL rst_mem_we got %h exp 0", mem_we);
    end
    checks++;
    if ({dma_gnt, dma_rvalid, dma_done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_dma_flags got %b exp 000",
               {dma_gnt, dma_rvalid, dma_done});
    end
    step();
    rst = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic test_cpu_only;
    cpu_re = 1'b1;
    cpu_addr = 32'h1000_0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_addr !== 32'h1000_0010 || mem_re !== 1'b1) begin
        errors++;
        $display("FAIL cpu_pass addr %h re %b exp 10000010 1",
                 mem_addr, mem_re);
      end
      checks++;
      if (cpu_stall !== 1'b0) begin
        errors++;
        $display("FAIL cpu_stall got %b exp 0", cpu_stall);
      end
      if (i > 0) begin
        checks++;
        if (cpu_dout !== memWord(32'h1000_0010)) begin
          errors++;
          $display("FAIL cpu_dout got %h exp %h",
                   cpu_dout, memWord(32'h1000_0010));
        end
      end
      step();
    end
    cpu_re = 1'b0;
    step();
  endtask

  task automatic test_dma_write(input logic [31:0] base,
                                input logic [3:0] len,
                                input int nBeats);
    int prevGnt = -1;
    int gnts = 0;
    int beat = 0;
    bit done = 1'b0;
    bit sawGnt;
    logic [31:0] exp;
    expQ.delete();
    for (int i = 0; i < nBeats; i++)
      expQ.push_back((base & 32'hFFFF_FFFC) + 32'(4 * i));
    dmaReq = 1'b1;
    dma_we = 1'b1;
    dma_addr = base;
    dma_len = len;
    dma_wdata = 32'hC0DE_0000;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checks++;
        if (dma_gnt !== 1'b0 || mem_we !== 4'h0) begin
          errors++;
          $display("FAIL wr_win gnt %b we %h exp 0 0", dma_gnt, mem_we);
        end
      end
      sawGnt = dma_gnt;
      if (dma_gnt) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL wr_extra_gnt got gnt %0d exp %0d",
                   gnts + 1, nBeats);
        end else begin
          exp = expQ.pop_front();
          if (mem_addr !== exp || mem_we !== 4'hF
              || mem_din !== 32'hC0DE_0000 + 32'(beat)) begin
            errors++;
            $display("FAIL wr_beat addr %h we %h din %h exp %h F %h",
                     mem_addr, mem_we, mem_din, exp,
                     32'hC0DE_0000 + 32'(beat));
          end
        end
        if (prevGnt >= 0) begin
          checks++;
          if (cyc != prevGnt + 1) begin
            errors++;
            $display("FAIL wr_consec got cyc %0d exp %0d",
                     cyc, prevGnt + 1);
          end
        end
        prevGnt = cyc;
        gnts++;
      end
      if (dma_done) begin
        checks++;
        if (gnts != nBeats || cyc != prevGnt + 1) begin
          errors++;
          $display("FAIL wr_done gnts %0d at %0d exp %0d at %0d",
                   gnts, cyc, nBeats, prevGnt + 1);
        end
        done = 1'b1;
      end
      step();
      if (sawGnt) begin
        beat++;
        dma_wdata = 32'hC0DE_0000 + 32'(beat);
      end
      if (done) dmaReq = 1'b0;
    end
    dmaReq = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wr_timeout got done 0 exp 1");
    end
    step();
  endtask

  task automatic test_dma_read_stall;
    int nRv = 0;
    bit done = 1'b0;
    logic [31:0] exp;
    expQ.delete();
    for (int i = 0; i < 3; i++)
      expQ.push_back(memWord(32'h3000_0000 + 32'(4 * i)));
    dmaReq = 1'b1;
    dma_we = 1'b0;
    dma_addr = 32'h3000_0000;
    dma_len = 4'd3;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) begin
        checks++;
        if (cpu_stall !== 1'b1) begin
          errors++;
          $display("FAIL rd_cpu_stall cyc %0d got %b exp 1",
                   cyc, cpu_stall);
        end
      end
      if (dma_rvalid) begin
        nRv++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rd_extra_rvalid got %0d exp 3", nRv);
        end else begin
          exp = expQ.pop_front();
          if (dma_rdata !== exp) begin
            errors++;
            $display("FAIL rd_data got %h exp %h", dma_rdata, exp);
          end
        end
      end
      if (dma_done) begin
        checks++;
        if (nRv != 3 || dma_rvalid !== 1'b1) begin
          errors++;
          $display("FAIL rd_done rvalids %0d rv %b exp 3 1",
                   nRv, dma_rvalid);
        end
        done = 1'b1;
      end
      step();
      if (cyc == 0) begin
        cpu_re = 1'b1;
        cpu_addr = 32'h2000;
      end
      mem_stall = (cyc + 1 == 2) || (cyc + 1 == 3);
      if (done) dmaReq = 1'b0;
    end
    dmaReq = 1'b0;
    mem_stall = 1'b0;
    checks++;
    if (!done || expQ.size() != 0) begin
      errors++;
      $display("FAIL rd_complete done %b left %0d exp 1 0",
               done, expQ.size());
    end
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || mem_re !== 1'b1 || dma_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_after stall %b re %b rv %b exp 0 1 0",
               cpu_stall, mem_re, dma_rvalid);
    end
    step();
    cpu_re = 1'b0;
    step();
  endtask

  task automatic test_starve;
    int denied = 0;
    int gntSeen = 0;
    bit won = 1'b0;
    bit done = 1'b0;
    cpu_re = 1'b1;
    cpu_addr = 32'h500;
    dmaReq = 1'b1;
    dma_we = 1'b1;
    dma_len = 4'd1;
    dma_addr = 32'h600;
    for (int cyc = 0; cyc < 40 && !won; cyc++) begin
      @(negedge clk);
      if (mem_re === 1'b1 && cpu_stall === 1'b0 && dma_gnt === 1'b0)
        denied++;
      else
        won = 1'b1;
      step();
    end
`ifdef MEM_PORT_ARB_STARVE_EN
    checks++;
    if (!won || denied != 16) begin
      errors++;
      $display("FAIL starve_win won %b denied %0d exp 1 16",
               won, denied);
    end
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (dma_gnt) begin
        gntSeen++;
        checks++;
        if (mem_addr !== 32'h600) begin
          errors++;
          $display("FAIL starve_addr got %h exp 600", mem_addr);
        end
      end
      if (dma_done) done = 1'b1;
      step();
    end
    checks++;
    if (!done || gntSeen != 1) begin
      errors++;
      $display("FAIL starve_burst done %b gnts %0d exp 1 1",
               done, gntSeen);
    end
`else
    checks++;
    if (won || denied != 40) begin
      errors++;
      $display("FAIL strict_prio won %b denied %0d exp 0 40",
               won, denied);
    end
`endif
    dmaReq = 1'b0;
    step();
    cpu_re = 1'b0;
    step();
  endtask

  task automatic test_reset_midburst;
    dmaReq = 1'b1;
    dma_we = 1'b0;
    dma_len = 4'd8;
    dma_addr = 32'h7000;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || mem_addr !== 32'h7000) begin
      errors++;
      $display("FAIL mid_beat0 gnt %b addr %h exp 1 7000",
               dma_gnt, mem_addr);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_re !== 1'b0 || cpu_stall !== 1'b1 || dma_gnt !== 1'b0
          || dma_rvalid !== 1'b0 || dma_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst re %b st %b g %b rv %b d %b exp 0 1 0 0 0",
                 mem_re, cpu_stall, dma_gnt, dma_rvalid, dma_done);
      end
      step();
      dmaReq = 1'b0;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_re !== 1'b0 || dma_gnt !== 1'b0
          || dma_rvalid !== 1'b0 || dma_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_after re %b g %b rv %b d %b exp 0 0 0 0",
                 mem_re, dma_gnt, dma_rvalid, dma_done);
      end
      step();
    end
    cpu_re = 1'b1;
    cpu_addr = 32'h800;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || cpu_stall !== 1'b0 || mem_addr !== 32'h800) begin
      errors++;
      $display("FAIL mid_idle re %b st %b addr %h exp 1 0 800",
               mem_re, cpu_stall, mem_addr);
    end
    step();
    cpu_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = '0;
    cpu_re = 1'b0;
    cpu_we = 4'h0;
    cpu_din = '0;
    dmaReq = 1'b0;
    dma_we = 1'b0;
    dma_addr = '0;
    dma_len = '0;
    dma_wdata = '0;
    mem_stall = 1'b0;
    test_reset();
    test_cpu_only();
    test_dma_write(32'h1FFF_FFF8, 4'd4, 4);
    test_dma_write(32'h0000_0103, 4'd0, 8);
    test_dma_write(32'h0000_0200, 4'd12, 8);
    test_dma_read_stall();
    test_starve();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
